// File: rtl/id_fwd_unit.sv
// rtl/id_fwd_unit.sv - decode-stage operand resolution with youngest-first bypass and stall counting
module id_fwd_unit #(
    parameter int XLEN      = 32,
    parameter int AREG_W    = 5,
    parameter int NSRC      = 3,
    parameter int NFWD      = 3,
    parameter int PAYLOAD_W = 64,
    parameter int CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_allowin,
    input  logic [PAYLOAD_W-1:0]   in_payload,
    input  logic [NSRC-1:0]        in_src_en,
    input  logic [NSRC*AREG_W-1:0] in_src_addr,
    output logic [NSRC*AREG_W-1:0] rf_raddr,
    input  logic [NSRC*XLEN-1:0]   rf_rdata,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD*AREG_W-1:0] fwd_dest,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    input  logic [NFWD-1:0]        fwd_data_ok,
    output logic                   out_valid,
    input  logic                   out_allowin,
    output logic [PAYLOAD_W-1:0]   out_payload,
    output logic [NSRC*XLEN-1:0]   out_src_data,
    input  logic                   flush,
    output logic [31:0]            stall_cnt
);
    // Saturation point; CNT_W below 32 gives a narrow counter that saturates early.
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF >> (32 - CNT_W);

    logic                   ds_valid_q, ds_valid_d;
    logic [PAYLOAD_W-1:0]   payload_q, payload_d;
    logic [NSRC-1:0]        src_en_q, src_en_d;
    logic [NSRC*AREG_W-1:0] src_addr_q, src_addr_d;
    logic [31:0]            stall_cnt_q, stall_cnt_d;
    logic [NSRC-1:0]        src_block;
    logic                   ready_go;
    logic                   accept;

    always_comb begin : resolve
        out_src_data = rf_rdata;
        src_block    = '0;
        for (int i = 0; i < NSRC; i++) begin
            // Walk oldest to youngest so the youngest match is the last one written.
            for (int s = NFWD - 1; s >= 0; s--) begin
                if (src_en_q[i] && (src_addr_q[i*AREG_W +: AREG_W] != '0) &&
                    fwd_valid[s] && fwd_we[s] &&
                    (fwd_dest[s*AREG_W +: AREG_W] == src_addr_q[i*AREG_W +: AREG_W])) begin
                    out_src_data[i*XLEN +: XLEN] = fwd_data[s*XLEN +: XLEN];
                    src_block[i]                 = !fwd_data_ok[s];
                end
            end
        end
    end

    assign ready_go    = ~|src_block;
    assign out_valid   = ds_valid_q && ready_go && !flush;
    assign in_allowin  = !ds_valid_q || (ready_go && out_allowin) || flush;
    assign accept      = in_valid && in_allowin;
    assign rf_raddr    = src_addr_q;
    assign out_payload = payload_q;
    assign stall_cnt   = stall_cnt_q;

    always_comb begin : next_state
        ds_valid_d  = in_allowin ? in_valid : ds_valid_q;
        payload_d   = accept ? in_payload  : payload_q;
        src_en_d    = accept ? in_src_en   : src_en_q;
        src_addr_d  = accept ? in_src_addr : src_addr_q;
        stall_cnt_d = stall_cnt_q;
        if (ds_valid_q && !ready_go && !flush && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid_q  <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            ds_valid_q  <= ds_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // The held instruction fields need no reset; ds_valid_q qualifies them.
    always_ff @(posedge clk) begin
        payload_q  <= payload_d;
        src_en_q   <= src_en_d;
        src_addr_q <= src_addr_d;
    end
endmodule

// File: tb/tb_id_fwd_unit.sv
// tb/tb_id_fwd_unit.sv - directed table, corner sequences and random run of id_fwd_unit against a reference model
module tb_id_fwd_unit;
    logic         clk, reset;
    logic         in_valid, out_allowin, flush;
    logic [63:0]  in_payload;
    logic [2:0]   in_src_en;
    logic [14:0]  in_src_addr;
    logic [95:0]  rf_rdata;
    logic [2:0]   fwd_valid, fwd_we, fwd_data_ok;
    logic [14:0]  fwd_dest;
    logic [95:0]  fwd_data;
    logic         in_allowin, out_valid;
    logic [14:0]  rf_raddr;
    logic [63:0]  out_payload;
    logic [95:0]  out_src_data;
    logic [31:0]  stall_cnt;
    logic         in_allowin2, out_valid2;
    logic [14:0]  rf_raddr2;
    logic [63:0]  out_payload2;
    logic [95:0]  out_src_data2;
    logic [31:0]  stall_cnt2;

    logic [31:0]  rfile [32];
    int           n_chk = 0;
    int           n_fail = 0;

    logic         m_valid;
    logic [63:0]  m_payload;
    logic [2:0]   m_en;
    logic [4:0]   m_addr [3];
    logic [31:0]  m_cnt, m_cnt2;
    logic [31:0]  exp_data [3];
    logic         exp_ready, exp_ov, exp_allowin;

    id_fwd_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_allowin(in_allowin),
        .in_payload(in_payload), .in_src_en(in_src_en), .in_src_addr(in_src_addr),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .fwd_valid(fwd_valid), .fwd_we(fwd_we),
        .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok),
        .out_valid(out_valid), .out_allowin(out_allowin), .out_payload(out_payload),
        .out_src_data(out_src_data), .flush(flush), .stall_cnt(stall_cnt)
    );

    id_fwd_unit #(.CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_allowin(in_allowin2),
        .in_payload(in_payload), .in_src_en(in_src_en), .in_src_addr(in_src_addr),
        .rf_raddr(rf_raddr2), .rf_rdata(rf_rdata), .fwd_valid(fwd_valid), .fwd_we(fwd_we),
        .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok),
        .out_valid(out_valid2), .out_allowin(out_allowin), .out_payload(out_payload2),
        .out_src_data(out_src_data2), .flush(flush), .stall_cnt(stall_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rf_rdata = '0;
        for (int i = 0; i < 3; i++) rf_rdata[i*32 +: 32] = rfile[rf_raddr[i*5 +: 5]];
    end

    typedef struct {
        logic        iv;
        logic        en0;
        logic [4:0]  a0;
        logic        en1;
        logic [4:0]  a1;
        logic [2:0]  fv, fwe, fok;
        logic [4:0]  d0, d1, d2;
        logic [31:0] x0, x1, x2;
        logic        oa, fl;
        logic        e_valid, e_allowin;
        logic [31:0] e_cnt, e_src0, e_src1;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: each source takes the first (youngest) stage in index order whose destination matches.
    task automatic model_eval();
        exp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int sel;
            sel = -1;
            exp_data[i] = (m_addr[i] == 5'd0) ? 32'd0 : rfile[m_addr[i]];
            if (m_en[i] && m_addr[i] != 5'd0) begin
                for (int s = 0; s < 3; s++) begin
                    if (sel < 0 && fwd_valid[s] && fwd_we[s] && fwd_dest[s*5 +: 5] == m_addr[i]) sel = s;
                end
            end
            if (sel >= 0) begin
                exp_data[i] = fwd_data[sel*32 +: 32];
                if (!fwd_data_ok[sel]) exp_ready = 1'b0;
            end
        end
        exp_ov      = m_valid && exp_ready && !flush;
        exp_allowin = !m_valid || (exp_ready && out_allowin) || flush;
    endtask

    task automatic check_outputs(input string tag);
        model_eval();
        chk({tag, " out_valid"}, out_valid, exp_ov);
        chk({tag, " in_allowin"}, in_allowin, exp_allowin);
        chk({tag, " stall_cnt"}, stall_cnt, m_cnt);
        chk({tag, " stall_cnt_narrow"}, stall_cnt2, m_cnt2);
        if (exp_ov) begin
            chk({tag, " payload"}, out_payload, m_payload);
            for (int i = 0; i < 3; i++) chk($sformatf("%s src%0d", tag, i), out_src_data[i*32 +: 32], exp_data[i]);
        end
    endtask

    task automatic tick();
        model_eval();
        if (reset) begin
            m_valid = 1'b0;
            m_cnt   = 32'd0;
            m_cnt2  = 32'd0;
        end else begin
            if (m_valid && !exp_ready && !flush) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                if (m_cnt2 != 32'd7) m_cnt2 = m_cnt2 + 32'd1;
            end
            if (exp_allowin) begin
                m_valid = in_valid;
                if (in_valid) begin
                    m_payload = in_payload;
                    m_en      = in_src_en;
                    for (int i = 0; i < 3; i++) m_addr[i] = in_src_addr[i*5 +: 5];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input vec_t v, input int k);
        in_valid    = v.iv;
        in_payload  = {32'hC0DE_0000, 32'(k)};
        in_src_en   = {1'b0, v.en1, v.en0};
        in_src_addr = {5'd0, v.a1, v.a0};
        fwd_valid   = v.fv;
        fwd_we      = v.fwe;
        fwd_data_ok = v.fok;
        fwd_dest    = {v.d2, v.d1, v.d0};
        fwd_data    = {v.x2, v.x1, v.x0};
        out_allowin = v.oa;
        flush       = v.fl;
    endtask

    task automatic quiet_fwd();
        fwd_valid = '0; fwd_we = '0; fwd_data_ok = '1; fwd_dest = '0; fwd_data = '0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rfile[r] = {16'(r), 16'(r)};
        rfile[5] = 32'h1234;
        m_valid = 0; m_payload = '0; m_en = '0; m_cnt = '0; m_cnt2 = '0;
        for (int i = 0; i < 3; i++) m_addr[i] = '0;

        //          iv en0 a0 en1 a1  fv      fwe     fok     d0 d1 d2 x0             x1        x2       oa fl  ev ea cnt src0           src1
        tbl[0]  = '{1, 1, 5, 0, 0, 3'b000, 3'b000, 3'b111, 0, 0, 0, 0,             0,        0,       1, 0,  0, 1, 0, 0,             0};
        tbl[1]  = '{1, 1, 7, 0, 0, 3'b101, 3'b101, 3'b111, 7, 0, 7, 32'hAAAA_0000, 0,        32'h5555, 1, 0, 1, 1, 0, 32'h1234,      0};
        tbl[2]  = '{1, 1, 3, 0, 0, 3'b101, 3'b101, 3'b111, 7, 0, 7, 32'hAAAA_0000, 0,        32'h5555, 1, 0, 1, 1, 0, 32'hAAAA_0000, 0};
        tbl[3]  = '{1, 1, 0, 0, 6, 3'b011, 3'b011, 3'b110, 3, 3, 0, 32'h0BAD,      1,        0,       1, 0,  0, 0, 0, 0,             0};
        tbl[4]  = '{1, 1, 0, 0, 6, 3'b110, 3'b110, 3'b111, 0, 3, 3, 0,             32'hDEAD, 1,       1, 0,  1, 1, 1, 32'hDEAD,      0};
        tbl[5]  = '{1, 1, 5, 0, 0, 3'b011, 3'b011, 3'b101, 0, 6, 0, 32'h1111,      32'h2222, 0,       1, 0,  1, 1, 1, 0,             32'h0006_0006};
        tbl[6]  = '{1, 1, 9, 0, 0, 3'b000, 3'b000, 3'b111, 0, 0, 0, 0,             0,        0,       0, 0,  1, 0, 1, 32'h1234,      0};
        tbl[7]  = tbl[6];
        tbl[8]  = tbl[6];
        tbl[9]  = '{1, 1, 9, 0, 0, 3'b000, 3'b000, 3'b111, 0, 0, 0, 0,             0,        0,       0, 1,  0, 1, 1, 0,             0};
        tbl[10] = '{0, 1, 9, 0, 0, 3'b000, 3'b000, 3'b111, 0, 0, 0, 0,             0,        0,       1, 0,  1, 1, 1, 32'h0009_0009, 0};
        tbl[11] = '{1, 1, 3, 0, 0, 3'b000, 3'b000, 3'b111, 0, 0, 0, 0,             0,        0,       1, 0,  0, 1, 1, 0,             0};
        tbl[12] = '{0, 1, 3, 0, 0, 3'b001, 3'b001, 3'b110, 3, 0, 0, 32'h77,        0,        0,       1, 0,  0, 0, 1, 0,             0};
        tbl[13] = '{0, 1, 3, 0, 0, 3'b001, 3'b001, 3'b110, 3, 0, 0, 32'h77,        0,        0,       1, 1,  0, 1, 2, 0,             0};
        tbl[14] = '{0, 1, 3, 0, 0, 3'b000, 3'b000, 3'b111, 0, 0, 0, 0,             0,        0,       1, 0,  0, 1, 2, 0,             0};

        reset = 1; in_valid = 0; in_payload = '0; in_src_en = '0; in_src_addr = '0;
        out_allowin = 1; flush = 0;
        quiet_fwd();
        tick();
        tick();
        reset = 0;
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset in_allowin", in_allowin, 1);
        chk("reset stall_cnt", stall_cnt, 0);

        for (int k = 0; k < 15; k++) begin
            apply_vec(tbl[k], k);
            #1;
            chk($sformatf("vec%0d out_valid", k), out_valid, tbl[k].e_valid);
            chk($sformatf("vec%0d in_allowin", k), in_allowin, tbl[k].e_allowin);
            chk($sformatf("vec%0d stall_cnt", k), stall_cnt, tbl[k].e_cnt);
            if (tbl[k].e_valid) begin
                chk($sformatf("vec%0d src0", k), out_src_data[31:0], tbl[k].e_src0);
                chk($sformatf("vec%0d src1", k), out_src_data[63:32], tbl[k].e_src1);
            end
            check_outputs($sformatf("vec%0d model", k));
            tick();
        end

        // Reset during a stall wins over a simultaneous flush and accept.
        flush = 0; out_allowin = 1; quiet_fwd();
        in_valid = 1; in_src_en = 3'b001; in_src_addr = {10'd0, 5'd3}; in_payload = 64'h1;
        tick();
        in_valid = 0;
        fwd_valid = 3'b001; fwd_we = 3'b001; fwd_dest = {10'd0, 5'd3}; fwd_data_ok = 3'b110;
        for (int c = 0; c < 3; c++) begin
            #1; check_outputs("stall_pre_reset"); tick();
        end
        reset = 1; flush = 1; in_valid = 1;
        tick();
        reset = 0; flush = 0; in_valid = 0;
        #1;
        chk("reset_mid_stall out_valid", out_valid, 0);
        chk("reset_mid_stall in_allowin", in_allowin, 1);
        chk("reset_mid_stall stall_cnt", stall_cnt, 0);

        // Long stall: the narrow counter must stop at its all-ones value.
        quiet_fwd();
        in_valid = 1; in_src_en = 3'b001; in_src_addr = {10'd0, 5'd3};
        tick();
        in_valid = 0;
        fwd_valid = 3'b001; fwd_we = 3'b001; fwd_dest = {10'd0, 5'd3}; fwd_data_ok = 3'b110;
        for (int c = 0; c < 12; c++) tick();
        #1;
        chk("sat narrow stall_cnt", stall_cnt2, 32'd7);
        chk("sat wide stall_cnt", stall_cnt, 32'd12);
        chk("sat out_valid", out_valid, 0);
        flush = 1;
        tick();
        flush = 0;

        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom % 4) != 0;
            in_payload  = {$urandom, $urandom};
            in_src_en   = 3'($urandom);
            for (int i = 0; i < 3; i++) in_src_addr[i*5 +: 5] = 5'($urandom_range(0, 3));
            fwd_valid   = 3'($urandom);
            fwd_we      = 3'($urandom);
            for (int s = 0; s < 3; s++) begin
                fwd_data_ok[s]        = ($urandom % 4) != 0;
                fwd_dest[s*5 +: 5]    = 5'($urandom_range(0, 3));
                fwd_data[s*32 +: 32]  = $urandom;
            end
            out_allowin = ($urandom % 4) != 0;
            flush       = ($urandom % 16) == 0;
            reset       = ($urandom % 200) == 0;
            #1;
            check_outputs("random");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
